// File: rtl/dht_pkg.sv
// Shared types and constants for the single-wire humidity/temperature sensor sequencer.
package dht_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NO_RESP  = 2'd1;
  localparam logic [1:0] ERR_BIT_TO   = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  localparam int unsigned NUM_BITS = 40;

  typedef struct packed {
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
  } reading_t;

  // Frame layout, MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
  function automatic reading_t frame_fields(input logic [39:0] frame);
    return reading_t'(frame[39:8]);
  endfunction

  function automatic logic checksum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return sum == frame[7:0];
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Divides the system clock down to a one-cycle pulse every microsecond.
module us_tick_gen #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_controller.sv
// Single-wire humidity/temperature sensor sequencer: start pulse, preamble check, 40-bit decode.
// Define DHT_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht_controller
  import dht_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned BIT_THRESH_US = 40,
  parameter int unsigned TIMEOUT_US    = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       read,
  output logic       dir,
  output logic       send,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam logic [15:0] START_LAST   = 16'(START_LOW_US - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
  localparam logic [15:0] THRESH       = 16'(BIT_THRESH_US);
  localparam logic [5:0]  LAST_BIT     = 6'(NUM_BITS - 1);

  state_t        state;
  state_t        state_nx;
  logic          tick;
  logic [15:0]   us_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   shift_q;
  reading_t      reading;
  logic          read_meta;
  logic          read_sync;
  logic          read_prev;
  logic          rise;
  logic          fall;
  logic          timeout;

  us_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // The idle line is pulled up, so the synchronizer resets to 1 to avoid a false fall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_meta <= 1'b1;
      read_sync <= 1'b1;
      read_prev <= 1'b1;
    end else begin
      read_meta <= read;
      read_sync <= read_meta;
      read_prev <= read_sync;
    end
  end

  assign rise    = read_sync & ~read_prev;
  assign fall    = ~read_sync & read_prev;
  assign timeout = tick && (us_cnt >= TIMEOUT_LAST);

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start) state_nx = START_LOW;
      START_LOW: if (tick && us_cnt >= START_LAST) state_nx = RELEASE;
      RELEASE:   if (timeout) state_nx = FINISH; else if (fall) state_nx = RESP_LOW;
      RESP_LOW:  if (timeout) state_nx = FINISH; else if (rise) state_nx = RESP_HIGH;
      RESP_HIGH: if (timeout) state_nx = FINISH; else if (fall) state_nx = BIT_LOW;
      BIT_LOW:   if (timeout) state_nx = FINISH; else if (rise) state_nx = BIT_HIGH;
      BIT_HIGH: begin
        if (timeout)    state_nx = FINISH;
        else if (fall)  state_nx = (bit_cnt == LAST_BIT) ? CHECK : BIT_LOW;
      end
      CHECK:     state_nx = FINISH;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Every state entry restarts the microsecond count; it saturates rather than wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      us_cnt <= '0;
    end else if (state_nx != state) begin
      us_cnt <= '0;
    end else if (tick && us_cnt != 16'hFFFF) begin
      us_cnt <= us_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      reading  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            error    <= 1'b0;
            err_code <= ERR_NONE;
            bit_cnt  <= '0;
          end
        end
        RELEASE, RESP_LOW, RESP_HIGH: begin
          if (timeout) begin
            error    <= 1'b1;
            err_code <= ERR_NO_RESP;
          end
        end
        BIT_LOW: begin
          if (timeout) begin
            error    <= 1'b1;
            err_code <= ERR_BIT_TO;
          end
        end
        BIT_HIGH: begin
          if (timeout) begin
            error    <= 1'b1;
            err_code <= ERR_BIT_TO;
          end else if (fall) begin
            shift_q <= {shift_q[38:0], (us_cnt > THRESH)};
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        CHECK: begin
`ifdef DHT_CHECKSUM_EN
          if (checksum_ok(shift_q)) begin
            reading <= frame_fields(shift_q);
          end else begin
            error    <= 1'b1;
            err_code <= ERR_CHECKSUM;
          end
`else
          reading <= frame_fields(shift_q);
`endif
        end
        default: ;
      endcase
    end
  end

  // Decoded straight from the async-reset state so reset releases the line without a clock.
  assign dir  = (state == START_LOW);
  assign send = 1'b0;
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  assign hum_int  = reading.hum_int;
  assign hum_dec  = reading.hum_dec;
  assign temp_int = reading.temp_int;
  assign temp_dec = reading.temp_dec;

endmodule

// File: tb/tb_dht_controller.sv
// Self-checking bench for dht_controller: open-drain line model, behavioural sensor, reading model.
`timescale 1ns/1ps
module tb_dht_controller;

  // One "microsecond" tick every DIV clocks keeps whole frames short in simulation.
  localparam int          DIV      = 2;
  localparam int unsigned CLK_HZ   = DIV * 1_000_000;
  localparam int          START_US = 20;
  localparam int          TO_US    = 255;
`ifdef DHT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  logic       line;
  logic       dir, send, busy, done, error;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   sensor_bit = -1;
  bit   sensor_high = 1'b0;
  bit   sensor_abort = 1'b0;
  logic [7:0] exp_f [4] = '{8'h0, 8'h0, 8'h0, 8'h0};

  // Open-drain line: host pulls low when driving 0, sensor pulls low, otherwise pull-up.
  assign line = ~((dir & ~send) | sensor_low);

  dht_controller #(
    .CLK_FREQ_HZ  (CLK_HZ),
    .START_LOW_US (START_US),
    .BIT_THRESH_US(40),
    .TIMEOUT_US   (TO_US)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .read    (line),
    .dir     (dir),
    .send    (send),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .err_code(err_code),
    .hum_int (hum_int),
    .hum_dec (hum_dec),
    .temp_int(temp_int),
    .temp_dec(temp_dec)
  );

  always #10 clock = ~clock;

  always @(negedge clock) if (done === 1'b1) done_seen++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic us_wait(input int us);
    repeat (us * DIV) @(negedge clock);
  endtask

  function automatic logic [39:0] make_frame(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input int corrupt);
    int sum;
    sum = (int'(b0) + int'(b1) + int'(b2) + int'(b3) + corrupt) % 256;
    return {b0, b1, b2, b3, 8'(sum)};
  endfunction

  // Expected outcome from the frame rules alone: silent, stuck, checksum, or good.
  function automatic int model_code(input logic [39:0] f, input int stop_bit, input bit silent);
    int sum;
    if (silent) return 1;
    if (stop_bit < 40) return 2;
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    if (CHK_EN && sum != int'(f[7:0])) return 3;
    return 0;
  endfunction

  task automatic sensor_frame(input logic [39:0] f, input int stop_bit, input bit silent);
    int n;
    sensor_bit = -1;
    n = 0;
    while (dir !== 1'b1 && n < 200 * DIV) begin @(negedge clock); n++; end
    n = 0;
    while (dir !== 1'b0 && n < 100 * DIV) begin @(negedge clock); n++; end
    if (silent) return;
    us_wait($urandom_range(20, 40));
    sensor_low = 1'b1; us_wait(80);
    sensor_low = 1'b0; us_wait(80);
    for (int i = 0; i < 40; i++) begin
      if (sensor_abort) break;
      sensor_bit = i;
      sensor_low = 1'b1; us_wait(10);
      sensor_low = 1'b0;
      if (i == stop_bit) return;
      sensor_high = 1'b1;
      us_wait(f[39-i] ? $urandom_range(52, 75) : $urandom_range(15, 30));
      sensor_high = 1'b0;
    end
    if (!sensor_abort) begin sensor_low = 1'b1; us_wait(10); end
    sensor_low = 1'b0;
  endtask

  task automatic issue_start(input string name);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || dir !== 1'b1 || send !== 1'b0) begin
      fails++;
      $display("FAIL %s start: busy/dir/send got %b%b%b expected 110", name, busy, dir, send);
    end
    tests++;
    if (error !== 1'b0 || err_code !== 2'd0) begin
      fails++;
      $display("FAIL %s err clear: got %b/%0d expected 0/0", name, error, err_code);
    end
  endtask

  task automatic wait_done(input int max_us, output bit got, output int cycles);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < max_us * DIV) begin
      @(negedge clock);
      cycles++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic check_fields(input string name);
    tests++;
    if ({hum_int, hum_dec, temp_int, temp_dec} !== {exp_f[0], exp_f[1], exp_f[2], exp_f[3]}) begin
      fails++;
      $display("FAIL %s fields: got %h expected %h", name, {hum_int, hum_dec, temp_int, temp_dec},
               {exp_f[0], exp_f[1], exp_f[2], exp_f[3]});
    end
  endtask

  task automatic run_frame(input string name, input logic [39:0] f, input int stop_bit,
                           input bit poke_start);
    bit         got;
    int         cyc;
    int         code;
    int         d0;
    logic       err_at;
    logic [1:0] code_at;
    logic       done_after, busy_after;
    code = model_code(f, stop_bit, 1'b0);
    d0 = done_seen;
    got = 1'b0; cyc = 0; err_at = 1'b0; code_at = 2'd0; done_after = 1'b1; busy_after = 1'b1;
    fork
      sensor_frame(f, stop_bit, 1'b0);
      begin
        issue_start(name);
        if (poke_start) begin
          us_wait(100);
          start = 1'b1; @(negedge clock); start = 1'b0;
        end
        wait_done(6000, got, cyc);
        err_at = error;
        code_at = err_code;
        @(negedge clock);
        done_after = done;
        busy_after = busy;
      end
    join
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s done: no pulse within bound, expected one", name);
    end
    tests++;
    if (err_at !== (code != 0) || code_at !== 2'(code)) begin
      fails++;
      $display("FAIL %s err: got %b/%0d expected %b/%0d", name, err_at, code_at, code != 0, code);
    end
    tests++;
    if (done_after !== 1'b0 || busy_after !== 1'b0) begin
      fails++;
      $display("FAIL %s after done: done/busy got %b%b expected 00", name, done_after, busy_after);
    end
    if (code == 0) begin
      exp_f[0] = f[39:32]; exp_f[1] = f[31:24]; exp_f[2] = f[23:16]; exp_f[3] = f[15:8];
    end
    check_fields(name);
    if (poke_start) us_wait(20);
    tests++;
    if (done_seen - d0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s pulses: got %0d busy %b expected 1 busy 0", name, done_seen - d0, busy);
    end
  endtask

  task automatic test_reset();
    int hi;
    bit bad_send;
    bit got;
    int cyc;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if ({dir, send, busy, done, error, err_code} !== 7'b0) begin
      fails++;
      $display("FAIL reset ctrl: got %b expected 0000000", {dir, send, busy, done, error, err_code});
    end
    check_fields("reset");
    reset_n = 1'b1;
    @(negedge clock);
    issue_start("reset");
    hi = 1;
    bad_send = 1'b0;
    for (int n = 0; n < 40 * DIV; n++) begin
      @(negedge clock);
      if (dir !== 1'b1) break;
      if (send !== 1'b0) bad_send = 1'b1;
      hi++;
    end
    tests++;
    if (hi < 19 * DIV || hi > 21 * DIV || bad_send) begin
      fails++;
      $display("FAIL start_low width: got %0d cycles send_bad %b expected ~%0d", hi, bad_send, 20 * DIV);
    end
    wait_done(400, got, cyc);
    tests++;
    if (!got || err_code !== 2'd1) begin
      fails++;
      $display("FAIL reset silent: got done %b code %0d expected 1/1", got, err_code);
    end
    @(negedge clock);
  endtask

  task automatic test_good_frame();
    run_frame("good", {8'h37, 8'h00, 8'h19, 8'h05, 8'h55}, 40, 1'b0);
    tests++;
    if (hum_int !== 8'd55 || temp_int !== 8'd25 || temp_dec !== 8'd5) begin
      fails++;
      $display("FAIL good decode: got %0d/%0d/%0d expected 55/25/5", hum_int, temp_int, temp_dec);
    end
  endtask

  task automatic test_silent();
    bit got;
    int cyc;
    int n;
    issue_start("silent");
    n = 0;
    while (dir !== 1'b0 && n < 40 * DIV) begin @(negedge clock); n++; end
    wait_done(400, got, cyc);
    tests++;
    if (!got || cyc < 254 * DIV || cyc > 256 * DIV) begin
      fails++;
      $display("FAIL silent timing: got done %b after %0d cycles expected ~%0d", got, cyc, 255 * DIV);
    end
    tests++;
    if (error !== 1'b1 || err_code !== 2'd1) begin
      fails++;
      $display("FAIL silent err: got %b/%0d expected 1/1", error, err_code);
    end
    check_fields("silent");
    us_wait(5);
    tests++;
    if (error !== 1'b1 || err_code !== 2'd1) begin
      fails++;
      $display("FAIL silent hold: got %b/%0d expected 1/1", error, err_code);
    end
  endtask

  task automatic test_stuck_bit();
    run_frame("stuck", make_frame(8'h41, 8'h02, 8'h1C, 8'h07, 0), 12, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 2; k++) begin
      run_frame("random", make_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                     int'($urandom_range(0, 1))), 40, 1'b0);
    end
  endtask

  task automatic test_bad_checksum();
    run_frame("checksum", {8'h37, 8'h00, 8'h19, 8'h05, 8'h54}, 40, 1'b0);
  endtask

  task automatic test_start_while_busy();
    run_frame("busy_start", make_frame(8'h2A, 8'h05, 8'h16, 8'h03, 0), 40, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int d0;
    issue_start("rst_startlow");
    us_wait(5);
    reset_n = 1'b0;
    #1;
    tests++;
    if (dir !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_startlow async: dir/busy got %b%b expected 00", dir, busy);
    end
    exp_f = '{8'h0, 8'h0, 8'h0, 8'h0};
    @(negedge clock);
    reset_n = 1'b1;
    check_fields("rst_startlow");
    d0 = done_seen;
    fork
      sensor_frame(make_frame(8'h33, 8'h01, 8'h17, 8'h02, 0), 40, 1'b0);
      begin
        issue_start("rst_bithigh");
        n = 0;
        while (!(sensor_bit == 5 && sensor_high) && n < 2000 * DIV) begin @(negedge clock); n++; end
        tests++;
        if (n >= 2000 * DIV) begin
          fails++;
          $display("FAIL rst_bithigh reach: got no bit-5 high phase expected one");
        end
        us_wait(5);
        reset_n = 1'b0;
        sensor_abort = 1'b1;
        #1;
        tests++;
        if (dir !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
          fails++;
          $display("FAIL rst_bithigh async: dir/busy/done got %b%b%b expected 000", dir, busy, done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        us_wait(300);
      end
    join
    sensor_abort = 1'b0;
    tests++;
    if (done_seen != d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_bithigh quiet: got %0d done pulses busy %b expected 0/0", done_seen - d0, busy);
    end
    check_fields("rst_bithigh");
  endtask

  task automatic test_fresh_start();
    run_frame("fresh", make_frame(8'h3C, 8'h00, 8'h1A, 8'h09, 0), 40, 1'b0);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_silent();
    test_stuck_bit();
    test_random_frames();
    test_bad_checksum();
    test_start_while_busy();
    test_reset_mid_frame();
    test_fresh_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dht_controller.md
# dht_controller

Sequencer for the single-wire humidity/temperature sensor link. It drives the `dir`/`send` controls of the existing tri-state pad block and samples its `read` output. It issues the host start pulse, checks the sensor response preamble, times 40 data bits, and presents the decoded fields. It sits between the pad block and the display/UART logic that consumes readings.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency; sets the 1 µs tick divider.
- `START_LOW_US`, 18000, duration the host holds the line low.
- `BIT_THRESH_US`, 40, high-phase length above which a bit decodes as 1.
- `TIMEOUT_US`, 255, maximum wait in any sensor-driven phase.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a transaction; sampled only in IDLE.
- `read` in 1: line value from the pad block; asynchronous.
- `dir` out 1: 1 = pad drives `send`, 0 = pad released (pull-up).
- `send` out 1: value driven when `dir`=1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a transaction ends, good or bad.
- `error` out 1: valid with `done`; held until the next `start`.
- `err_code` out 2: 0 none, 1 no response, 2 bit timeout, 3 checksum.
- `hum_int`, `hum_dec`, `temp_int`, `temp_dec` out 8 each: last good reading.

## Operation
- `read` passes through a 2-flop synchronizer. All edge detection uses the synchronized value and its 1-cycle delayed copy.
- States and transitions:
  - IDLE: `start` leads to START_LOW.
  - START_LOW: `dir`=1, `send`=0 for `START_LOW_US`, then RELEASE.
  - RELEASE: `dir`=0. A falling edge leads to RESP_LOW. No falling edge within `TIMEOUT_US` is error 1.
  - RESP_LOW: a rising edge leads to RESP_HIGH. Timeout is error 1.
  - RESP_HIGH: a falling edge leads to BIT_LOW. Timeout is error 1.
  - BIT_LOW: a rising edge clears the µs counter and leads to BIT_HIGH. Timeout is error 2.
  - BIT_HIGH: on a falling edge, shift in (count > `BIT_THRESH_US`). After 40 bits go to CHECK, otherwise BIT_LOW. Timeout is error 2.
  - CHECK: compare the checksum, then FINISH.
  - FINISH: pulse `done`, return to IDLE.
- Bits are shifted MSB-first into a 40-bit register. Byte order: hum_int, hum_dec, temp_int, temp_dec, checksum.
- Checksum rule: the 8-bit modulo-256 sum of the first four bytes equals byte 4.
- Output fields update only on a good transaction. On error they hold their previous values.
- `start` while busy is ignored and not queued.
- The µs counter is 16 bits and saturates. It clears on every state entry.

## Timing
- Reset values: state IDLE, `dir`=0, `send`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, all data fields 0.
- Reset asserted mid-transaction releases the line (`dir`=0) asynchronously. No `done` pulse is produced.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `dir` rises in that same cycle.
- Synchronizer latency from pad to edge detect is 2 cycles. Decision timing is quantized to the 1 µs tick (±1 µs).
- `done` is exactly 1 cycle wide. It is asserted in FINISH, and `busy` falls in the following cycle.
- `error`/`err_code` are valid from the `done` cycle. They clear when the next `start` is accepted.
- A timeout terminates in the tick where the counter reaches `TIMEOUT_US`, with no further sampling. The timed-out state then transitions to FINISH.

## Configuration
- `DHT_CHECKSUM_EN`:
  - Defined: CHECK compares the checksum. A mismatch sets `error`=1, `err_code`=3, and the fields are not updated.
  - Undefined: CHECK always passes, fields always update after 40 bits, and `err_code` 3 is never produced.

## Structure
- Shared package `dht_pkg` holds:
  - the state enum (IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, FINISH);
  - `err_code` constants (ERR_NONE, ERR_NO_RESP, ERR_BIT_TO, ERR_CHECKSUM);
  - the bit-count constant 40.
- One sub-module, `us_tick_gen`: divides `clock` by `CLK_FREQ_HZ`/1_000_000 and emits a one-cycle `tick`. It is held in reset by `reset_n`.

## Test plan
Bench settings: 20 ns clock, `START_LOW_US`=20, and a behavioural sensor model on an open-drain line through the pad block.

- Reset check: apply reset, then pulse `start` → `dir`=1/`send`=0 for 20 µs, then `dir`=0.
- Good frame: sensor sends 80/80 µs preamble and bytes 0x37, 0x00, 0x19, 0x05, 0x55 → `done` pulse, `error`=0, `hum_int`=55, `temp_int`=25, `temp_dec`=5.
- Silent sensor: line stays high → `done` after 255 µs in RELEASE, `error`=1, `err_code`=1, fields unchanged.
- Stuck bit: sensor stops high after bit 12 → `err_code`=2, `busy` falls, previous fields held.
- Bad checksum: same bytes with checksum 0x54 → with `DHT_CHECKSUM_EN` defined, `err_code`=3 and fields held; without it, fields update and `error`=0.
- Disturbances:
  - `start` pulsed mid-frame is ignored; the frame completes normally.
  - `reset_n` low during BIT_HIGH releases `dir` immediately with no `done`.
  - A fresh `start` after release succeeds.
